bl_calc: RTL and testbench
==========================

BL_CALC -- requirements
Module: bl_calc

Interface
REQ-001 Parameter ADC_BIT_WIDTH, default 16, width of one signed two's-complement ADC sample.
REQ-002 Parameter NCH, default 4, number of channels packed in din/BL; channel n occupies bits [16n+15:16n].
REQ-003 Parameter MAX_SHIFT, default 10, largest log2 window size (1024 samples).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 din  input  NCH*ADC_BIT_WIDTH  packed channel samples, qualified by data_BL_valid.
REQ-007 data_BL_valid  input  1  high while din carries pre-trigger baseline samples.
REQ-008 bl_shift  input  4  log2 of the averaging window; sampled at window start.
REQ-009 BL  output  NCH*ADC_BIT_WIDTH  per-channel signed baseline average.
REQ-010 BL_update  output  1  level; high while BL holds the result of the latest window.
REQ-011 bl_err  output  1  high with BL_update when the window ended short.
REQ-012 busy  output  1  high from the window start until BL_update is asserted.

Function
REQ-013 States: IDLE, ACC, DIV, DONE. Encoded in 2 bits.
REQ-014 IDLE->ACC on the first cycle with data_BL_valid=1. That cycle's din is sample 0 and is accumulated. bl_shift is latched as k=min(bl_shift,MAX_SHIFT). Accumulators and counter restart. BL_update and bl_err clear.
REQ-015 In ACC, each cycle with data_BL_valid=1 adds the sign-extended din channel into a 26-bit signed accumulator for that channel and increments an 11-bit sample counter.
REQ-016 ACC->DIV in the cycle the counter reaches 2^k. Later samples in the same data_BL_valid burst are ignored.
REQ-017 ACC->DONE if data_BL_valid falls before 2^k samples are counted. BL is then forced to 0 and bl_err=1.
REQ-018 DIV lasts one cycle. BL[n] = accumulator[n] arithmetically shifted right by k, truncated to 16 bits (rounds toward minus infinity). Overflow is impossible by construction.
REQ-019 DIV->DONE. BL_update=1 on the first cycle in DONE, which is 2 clocks after the last accumulated sample. busy=0 in the same cycle.
REQ-020 DONE holds BL, BL_update and bl_err until a new rising edge of data_BL_valid, which re-enters ACC exactly as in REQ-014.
REQ-021 For k=0 the window is the single sample 0: ACC->DIV on the entry cycle and BL=din of that cycle.
REQ-022 Once in DONE, the block waits for data_BL_valid to return to 0 before a new rising edge is recognised. A level held high from DIV onward does not restart a window.
REQ-023 bl_shift changes during ACC have no effect on the current window.

Reset
REQ-024 When rst=0, the block asynchronously enters IDLE with BL=0, BL_update=0, bl_err=0, busy=0, and accumulators and counter at 0.
REQ-025 Reset asserted mid-window discards the partial sums. No BL_update is produced for that window.
REQ-026 After rst returns to 1, the first data_BL_valid rising edge starts a fresh window.

Structure
REQ-027 Shared package bl_pkg holds: ADC_BIT_WIDTH, NCH, MAX_SHIFT, ACC_W=ADC_BIT_WIDTH+MAX_SHIFT, CNT_W=MAX_SHIFT+1, and the state encodings.
REQ-028 One sub-module, bl_acc_chan, is instantiated NCH times. It provides clear, accumulate enable, sign extension, and the shifted 16-bit result.
REQ-029 The FSM, the window counter and the k latch reside in bl_calc only.

Verification
REQ-030 k=3, eight samples, ch0=100..107 and ch3=-8 constant -> BL ch0=103, ch3=-8, BL_update high 2 clocks after the 8th sample, bl_err=0.
REQ-031 k=2, data_BL_valid high for 3 samples then low -> BL=0, bl_err=1, BL_update=1.
REQ-032 k=10, 1024 samples all 0x7FFF on every channel, then 20 extra samples of 0 in the same burst -> BL=0x7FFF on all channels (no overflow, extras ignored).
REQ-033 k=1, samples -3 and 0 -> BL=-2 (floor), then bl_shift=15 on the next window -> clamped to a window of 1024.
REQ-034 rst pulsed low after 5 of 16 samples, then a clean 16-sample window of value 50 -> no BL_update before the second window, then BL=50.
REQ-035 Two back-to-back windows separated by one idle cycle -> BL_update drops on the second rising edge and reasserts with the new average.

Source files
------------

// File: rtl/bl_pkg.sv
// Shared widths and FSM state encoding for the baseline calculator.
package bl_pkg;

    localparam int unsigned ADC_BIT_WIDTH = 16;
    localparam int unsigned NCH           = 4;
    localparam int unsigned MAX_SHIFT     = 10;
    localparam int unsigned ACC_W         = ADC_BIT_WIDTH + MAX_SHIFT;
    localparam int unsigned CNT_W         = MAX_SHIFT + 1;
    localparam int unsigned SHIFT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bl_calc_acc_chan.sv
// One channel of the baseline accumulator: sign-extending sum and floor-divided result.
module bl_acc_chan
    import bl_pkg::*;
#(
    parameter int unsigned DW = ADC_BIT_WIDTH,
    parameter int unsigned AW = ACC_W,
    parameter int unsigned KW = SHIFT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic [KW-1:0] k,
    output logic [DW-1:0] res_c
);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] din_x;

    assign din_x = {{(AW-DW){din[DW-1]}}, din};

    // clr with en loads the first sample of a new window directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= en ? din_x : '0;
        end else if (en) begin
            acc <= acc + din_x;
        end
    end

    // arithmetic shift floors toward minus infinity
    assign res_c = DW'(acc >>> k);

endmodule

// File: rtl/bl_calc.sv
// Pre-trigger baseline averager: sums 2^k samples per channel and reports the floored mean.
module bl_calc #(
    parameter int unsigned ADC_BIT_WIDTH = bl_pkg::ADC_BIT_WIDTH,
    parameter int unsigned NCH           = bl_pkg::NCH,
    parameter int unsigned MAX_SHIFT     = bl_pkg::MAX_SHIFT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NCH*ADC_BIT_WIDTH-1:0] din,
    input  logic                         data_BL_valid,
    input  logic [3:0]                   bl_shift,
    output logic [NCH*ADC_BIT_WIDTH-1:0] BL,
    output logic                         BL_update,
    output logic                         bl_err,
    output logic                         busy
);

    import bl_pkg::*;

    localparam int unsigned AW = ADC_BIT_WIDTH + MAX_SHIFT;
    localparam int unsigned CW = MAX_SHIFT + 1;
    localparam int unsigned KW = 4;

    state_t                       state;
    state_t                       state_nx;
    logic [KW-1:0]                k;
    logic [KW-1:0]                k_new_c;
    logic [CW-1:0]                cnt;
    logic [CW-1:0]                cnt_inc_c;
    logic [CW-1:0]                target_c;
    logic                         valid_q;
    logic                         start_c;
    logic                         acc_en_c;
    logic                         load_c;
    logic                         short_c;
    logic [NCH*ADC_BIT_WIDTH-1:0] res_c;

    assign k_new_c   = (32'(bl_shift) > 32'(MAX_SHIFT)) ? KW'(MAX_SHIFT) : bl_shift;
    assign cnt_inc_c = cnt + CW'(1);
    assign target_c  = CW'(1) << k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // From DONE only a fresh rising edge of valid opens a window
    always_comb begin
        state_nx = state;
        start_c  = 1'b0;
        acc_en_c = 1'b0;
        load_c   = 1'b0;
        short_c  = 1'b0;
        case (state)
            IDLE: begin
                if (data_BL_valid) begin
                    start_c  = 1'b1;
                    acc_en_c = 1'b1;
                    state_nx = (k_new_c == '0) ? DIV : ACC;
                end
            end
            ACC: begin
                if (data_BL_valid) begin
                    acc_en_c = 1'b1;
                    if (cnt_inc_c == target_c) begin
                        state_nx = DIV;
                    end
                end else begin
                    short_c  = 1'b1;
                    state_nx = DONE;
                end
            end
            DIV: begin
                load_c   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                if (data_BL_valid && !valid_q) begin
                    start_c  = 1'b1;
                    acc_en_c = 1'b1;
                    state_nx = (k_new_c == '0) ? DIV : ACC;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Window bookkeeping and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k         <= '0;
            cnt       <= '0;
            valid_q   <= 1'b0;
            BL        <= '0;
            BL_update <= 1'b0;
            bl_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid_q <= data_BL_valid;
            if (start_c) begin
                k         <= k_new_c;
                cnt       <= CW'(1);
                BL_update <= 1'b0;
                bl_err    <= 1'b0;
                busy      <= 1'b1;
            end else if (acc_en_c) begin
                cnt <= cnt_inc_c;
            end
            if (load_c) begin
                BL        <= res_c;
                BL_update <= 1'b1;
                busy      <= 1'b0;
            end
            if (short_c) begin
                BL        <= '0;
                BL_update <= 1'b1;
                bl_err    <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        bl_acc_chan #(
            .DW(ADC_BIT_WIDTH),
            .AW(AW),
            .KW(KW)
        ) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (start_c),
            .en    (acc_en_c),
            .din   (din[n*ADC_BIT_WIDTH +: ADC_BIT_WIDTH]),
            .k     (k),
            .res_c (res_c[n*ADC_BIT_WIDTH +: ADC_BIT_WIDTH])
        );
    end

endmodule

// File: tb/tb_bl_calc.sv
// Directed bench for bl_calc; status word packs {busy, bl_err, BL_update} into bits [2:0].
module tb_bl_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        data_BL_valid;
    logic [3:0]  bl_shift;
    logic [63:0] BL;
    logic        BL_update;
    logic        bl_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bl_calc dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .data_BL_valid (data_BL_valid),
        .bl_shift      (bl_shift),
        .BL            (BL),
        .BL_update     (BL_update),
        .bl_err        (bl_err),
        .busy          (busy)
    );

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] stat();
        return {61'd0, busy, bl_err, BL_update};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs read right after this return reflect the previous rising edge
    task automatic step(input logic v, input logic [63:0] d);
        @(negedge clk);
        din           = d;
        data_BL_valid = v;
    endtask

    initial begin
        rst           = 1'b0;
        data_BL_valid = 1'b0;
        din           = '0;
        bl_shift      = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset BL", BL, 64'd0);
        chk("reset stat", stat(), 64'd0);
        rst = 1'b1;

        // k=3, eight samples; bl_shift changes mid-window
        bl_shift = 4'd3;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, p4(100 + i, 1000, 2 * i - 7, -8));
            if (i == 1) chk("k3 busy", stat(), 64'h4);
            if (i == 2) bl_shift = 4'd0;
        end
        step(1'b0, '0);
        chk("k3 latency", stat(), 64'h4);
        step(1'b0, '0);
        chk("k3 stat", stat(), 64'h1);
        chk("k3 BL", BL, p4(103, 1000, 0, -8));

        // short window: k=2, only 3 samples
        bl_shift = 4'd2;
        step(1'b1, p4(1, 2, 3, 4));
        step(1'b1, p4(1, 2, 3, 4));
        chk("short clr", stat(), 64'h4);
        step(1'b1, p4(1, 2, 3, 4));
        step(1'b0, '0);
        chk("short busy", stat(), 64'h4);
        step(1'b0, '0);
        chk("short stat", stat(), 64'h3);
        chk("short BL", BL, 64'd0);

        // k=1 floor rounding
        bl_shift = 4'd1;
        step(1'b1, p4(-3, 3, -1, 5));
        step(1'b1, p4(0, 0, 0, 0));
        step(1'b0, '0);
        chk("k1 busy", stat(), 64'h4);
        step(1'b0, '0);
        chk("k1 stat", stat(), 64'h1);
        chk("k1 BL", BL, p4(-2, 1, -1, 2));

        // bl_shift=15 clamps to 1024 samples; alternating extremes average to -0.5
        bl_shift = 4'd15;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, (i % 2 == 0) ? p4(-32768, -32768, -32768, -32768)
                                    : p4(32767, 32767, 32767, 32767));
        end
        step(1'b0, '0);
        chk("clamp busy", stat(), 64'h4);
        step(1'b0, '0);
        chk("clamp stat", stat(), 64'h1);
        chk("clamp BL", BL, p4(-1, -1, -1, -1));

        // k=10 full scale, then 20 extra samples in the same burst
        bl_shift = 4'd10;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, p4(32767, 32767, 32767, 32767));
        end
        step(1'b1, '0);
        chk("k10 busy", stat(), 64'h4);
        step(1'b1, '0);
        chk("k10 stat", stat(), 64'h1);
        chk("k10 BL", BL, p4(32767, 32767, 32767, 32767));
        repeat (18) step(1'b1, '0);
        step(1'b0, '0);
        chk("k10 hold stat", stat(), 64'h1);
        chk("k10 hold BL", BL, p4(32767, 32767, 32767, 32767));
        step(1'b0, '0);

        // k=0: single-sample window, level held high must not restart
        bl_shift = 4'd0;
        step(1'b1, p4(5, -5, 32767, -32768));
        step(1'b1, p4(9, 9, 9, 9));
        chk("k0 busy", stat(), 64'h4);
        step(1'b1, p4(9, 9, 9, 9));
        chk("k0 stat", stat(), 64'h1);
        chk("k0 BL", BL, p4(5, -5, 32767, -32768));
        step(1'b0, '0);
        chk("k0 hold", stat(), 64'h1);
        step(1'b0, '0);

        // reset mid-window, then a clean 16-sample window
        bl_shift = 4'd4;
        for (int i = 0; i < 5; i++) step(1'b1, p4(77, 77, 77, 77));
        @(negedge clk);
        rst           = 1'b0;
        data_BL_valid = 1'b0;
        #1;
        chk("rst stat", stat(), 64'h0);
        chk("rst BL", BL, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0);
        chk("post rst stat", stat(), 64'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, p4(50, 50, 50, 50));
            if (i == 8) chk("rst win busy", stat(), 64'h4);
        end
        step(1'b0, '0);
        chk("rst win latency", stat(), 64'h4);
        step(1'b0, '0);
        chk("rst win stat", stat(), 64'h1);
        chk("rst win BL", BL, p4(50, 50, 50, 50));

        // back-to-back windows with a single idle cycle between them
        bl_shift = 4'd1;
        step(1'b1, p4(10, 10, 10, 10));
        step(1'b1, p4(20, 20, 20, 20));
        step(1'b0, '0);
        chk("b2b A busy", stat(), 64'h4);
        step(1'b1, p4(30, 30, 30, 30));
        chk("b2b A stat", stat(), 64'h1);
        chk("b2b A BL", BL, p4(15, 15, 15, 15));
        step(1'b1, p4(40, 40, 40, 40));
        chk("b2b drop", stat(), 64'h4);
        step(1'b0, '0);
        chk("b2b B busy", stat(), 64'h4);
        step(1'b0, '0);
        chk("b2b B stat", stat(), 64'h1);
        chk("b2b B BL", BL, p4(35, 35, 35, 35));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
